// File: rtl/facq_prn_packer.sv
// -----------------------------------------------------------------------------
// facq_prn_packer
//
// Downstream stage of the fast-acquisition PRN RAM. It takes the serial PRN
// sample stream (already repeated freq_div times upstream) and packs it
// LSB-first into WORD_WIDTH-bit words for the parallel correlator. The final
// word of each epoch is flagged with word_last and zero-padded above the last
// written sample. Completed words are queued in a small first-word-fall-through
// FIFO and leave the block through a valid/ready handshake.
//
// Build option:
//   FACQ_PRN_PACKER_EPOCH_CNT_EN - when defined, epoch_cnt_o counts accepted
//   epoch-final words (wrapping at 2^16). When undefined, epoch_cnt_o is tied
//   to zero and no counter logic exists.
//
// Ports:
//   clk_i          PRN-domain clock (same clock as the PRN RAM)
//   rst_i          synchronous, active-high reset; dominates every input
//   sync_i         realign pulse, asserted with the PRN RAM clr
//   epoch_len_i    samples per epoch; 0 selects continuous packing
//   prn_i          PRN sample
//   valid_i        prn_i qualifier
//   word_data_o    packed samples, bit 0 = oldest
//   word_last_o    word holds the epoch's final sample
//   word_valid_o   FIFO head valid
//   word_ready_i   consumer accepts the head
//   overflow_o     sticky: a completed word was dropped on a full FIFO
//   epoch_cnt_o    completed-epoch counter (build option, else 0)
//
// Notes:
//   The epoch compare is equality only. If epoch_len_i is lowered below the
//   running sample count without sync_i, samp_cnt wraps at 2^EPOCH_W before
//   the next epoch end is seen. Software changes epoch_len_i together with
//   sync_i to avoid this.
// -----------------------------------------------------------------------------
module facq_prn_packer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EPOCH_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sync_i,
  input  logic [EPOCH_W-1:0]    epoch_len_i,
  input  logic                  prn_i,
  input  logic                  valid_i,
  output logic [WORD_WIDTH-1:0] word_data_o,
  output logic                  word_last_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  overflow_o,
  output logic [15:0]           epoch_cnt_o
);

  localparam int unsigned BIT_W = $clog2(WORD_WIDTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [BIT_W-1:0]      BIT_ZERO   = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]      BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0]      BIT_LAST   = BIT_W'(WORD_WIDTH - 1);
  localparam logic [EPOCH_W-1:0]    EPOCH_ZERO = {EPOCH_W{1'b0}};
  localparam logic [EPOCH_W-1:0]    EPOCH_ONE  = EPOCH_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [WORD_WIDTH-1:0] WORD_ZERO  = {WORD_WIDTH{1'b0}};
  localparam logic [WORD_WIDTH:0]   ENTRY_ZERO = {(WORD_WIDTH + 1){1'b0}};

  // FIFO entry layout: {last, data}.
  typedef logic [WORD_WIDTH:0] entry_t;

  // ---------------------------------------------------------------------------
  // Packer state
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] shift_d;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [BIT_W-1:0]      bit_cnt_d;
  logic [EPOCH_W-1:0]    samp_cnt_q;
  logic [EPOCH_W-1:0]    samp_cnt_d;

  logic                  accept_s;
  logic                  word_end_s;
  logic                  epoch_end_s;
  logic                  complete_s;
  logic [WORD_WIDTH-1:0] filled_s;
  entry_t                push_entry_s;

  // ---------------------------------------------------------------------------
  // FIFO and registered output stage
  // ---------------------------------------------------------------------------
  entry_t                mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  entry_t                head_q;
  entry_t                head_d;
  logic                  head_valid_q;
  logic                  head_valid_d;
  logic                  overflow_q;
  logic                  overflow_d;

  logic                  pop_s;
  logic                  push_s;
  logic                  full_s;
  logic                  drop_s;

  // Packer datapath: sample insertion, word/epoch completion and counters.
  always_comb begin
    // A sample arriving together with sync belongs to the discarded alignment.
    accept_s   = valid_i & ~sync_i;
    word_end_s = (bit_cnt_q == BIT_LAST);
    if (epoch_len_i != EPOCH_ZERO) begin
      epoch_end_s = (samp_cnt_q == (epoch_len_i - EPOCH_ONE));
    end else begin
      epoch_end_s = 1'b0;
    end

    // Bits above bit_cnt_q are always zero here, which gives the zero
    // padding of a short epoch-final word for free.
    filled_s            = shift_q;
    filled_s[bit_cnt_q] = prn_i;

    complete_s   = accept_s & (word_end_s | epoch_end_s);
    push_entry_s = {epoch_end_s, filled_s};

    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    samp_cnt_d = samp_cnt_q;

    if (sync_i) begin
      shift_d    = WORD_ZERO;
      bit_cnt_d  = BIT_ZERO;
      samp_cnt_d = EPOCH_ZERO;
    end else if (accept_s) begin
      // Counters advance even if the completed word is dropped later, so
      // epoch alignment survives an overflow.
      if (complete_s) begin
        shift_d   = WORD_ZERO;
        bit_cnt_d = BIT_ZERO;
      end else begin
        shift_d   = filled_s;
        bit_cnt_d = bit_cnt_q + BIT_ONE;
      end
      if (epoch_end_s) begin
        samp_cnt_d = EPOCH_ZERO;
      end else begin
        samp_cnt_d = samp_cnt_q + EPOCH_ONE;
      end
    end else begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      samp_cnt_d = samp_cnt_q;
    end
  end

  // FIFO bookkeeping plus the next head value for the registered outputs.
  always_comb begin
    pop_s  = head_valid_q & word_ready_i;
    full_s = (cnt_q == CNT_FULL);
    // A pop on the completion cycle frees the slot the push needs.
    push_s = complete_s & (~full_s | pop_s);
    drop_s = complete_s & full_s & ~pop_s;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;

    if (sync_i) begin
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      cnt_d      = CNT_ZERO;
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
      overflow_d = overflow_q | drop_s;
    end

    // The head register mirrors the FIFO slot at the next read pointer. When
    // that slot is the one being written this cycle, forward the new word so
    // an empty FIFO presents it on the very next cycle.
    head_valid_d = (cnt_d != CNT_ZERO);
    if (cnt_d == CNT_ZERO) begin
      head_d = ENTRY_ZERO;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= ENTRY_ZERO;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  // Packer, FIFO pointer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q      <= WORD_ZERO;
      bit_cnt_q    <= BIT_ZERO;
      samp_cnt_q   <= EPOCH_ZERO;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      cnt_q        <= CNT_ZERO;
      head_q       <= ENTRY_ZERO;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign word_data_o  = head_q[WORD_WIDTH-1:0];
  assign word_last_o  = head_q[WORD_WIDTH];
  assign word_valid_o = head_valid_q;
  assign overflow_o   = overflow_q;

`ifdef FACQ_PRN_PACKER_EPOCH_CNT_EN
  logic [15:0] epoch_cnt_q;
  logic [15:0] epoch_cnt_d;

  // Completed-epoch counter: only epoch-final words that enter the FIFO count.
  always_comb begin
    if (sync_i) begin
      epoch_cnt_d = 16'd0;
    end else if (push_s && epoch_end_s) begin
      epoch_cnt_d = epoch_cnt_q + 16'd1;
    end else begin
      epoch_cnt_d = epoch_cnt_q;
    end
  end

  // Completed-epoch counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      epoch_cnt_q <= 16'd0;
    end else begin
      epoch_cnt_q <= epoch_cnt_d;
    end
  end

  assign epoch_cnt_o = epoch_cnt_q;
`else
  assign epoch_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_facq_prn_packer.sv
module tb_facq_prn_packer;

  localparam int W = 32;
  typedef logic [W:0] entry_t;  // {last, data}

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_in;
  logic [15:0] epoch_len;
  logic        prn;
  logic        valid;
  logic        word_ready;
  logic [W-1:0] word_data;
  logic        word_last;
  logic        word_valid;
  logic        overflow;
  logic [15:0] epoch_cnt;

  int errors = 0;
  int checks = 0;

  logic   samp [0:511];
  logic   ep_samp [0:79];
  int     sidx;
  entry_t got_q[$];
  entry_t exp_q[$];

  always #5 clk = ~clk;

  facq_prn_packer #(
    .WORD_WIDTH(32),
    .FIFO_DEPTH(4),
    .EPOCH_W(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sync_i       (sync_in),
    .epoch_len_i  (epoch_len),
    .prn_i        (prn),
    .valid_i      (valid),
    .word_data_o  (word_data),
    .word_last_o  (word_last),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .overflow_o   (overflow),
    .epoch_cnt_o  (epoch_cnt)
  );

  // One clock: drive inputs, note a pop happening at this edge, then sample
  // 1 time unit after the edge.
  task automatic run_cycle(input logic v, input logic p, input logic s);
    valid   = v;
    prn     = p;
    sync_in = s;
    if (!rst && !s && word_valid && word_ready)
      got_q.push_back({word_last, word_data});
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      samp[sidx] = 1'($urandom_range(0, 1));
      run_cycle(1'b1, samp[sidx], 1'b0);
      sidx++;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic do_reset(input logic [15:0] len);
    rst = 1'b1;
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    epoch_len = len;
    got_q.delete();
    exp_q.delete();
    sidx = 0;
  endtask

  // Reference model: sample i sits at epoch position i mod len (or i when
  // continuous); each word starts at a multiple of W within the epoch.
  task automatic model_pack(input int n, input int len);
    logic [W-1:0] w;
    int pos;
    int bitp;
    logic is_last;
    w = '0;
    for (int i = 0; i < n; i++) begin
      pos     = (len == 0) ? i : (i % len);
      bitp    = pos % W;
      w[bitp] = samp[i];
      is_last = (len != 0) && (pos == len - 1);
      if (bitp == W - 1 || is_last) begin
        exp_q.push_back({is_last, w});
        w = '0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    word_ready = 1'b1;
    epoch_len = 16'd40;
    for (int i = 0; i < 4; i++)
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    checks++; if (word_data !== 32'd0) begin errors++; $display("FAIL reset_word_data: got %h expected 0", word_data); end
    checks++; if (word_last !== 1'b0) begin errors++; $display("FAIL reset_word_last: got %b expected 0", word_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (epoch_cnt !== 16'd0) begin errors++; $display("FAIL reset_epoch_cnt: got %0d expected 0", epoch_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_epoch();
    entry_t e;
    logic [15:0] exp_ec;
    do_reset(16'd40);
    word_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      samp[sidx] = 1'($urandom_range(0, 1));
      run_cycle(1'b1, samp[sidx], 1'b0);
      sidx++;
      if (i == 30) begin
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL epoch_latency_early: got %b expected 0", word_valid); end
      end
      if (i == 31) begin
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL epoch_latency: got %b expected 1", word_valid); end
      end
    end
    drain(6);
    model_pack(80, 40);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL epoch_word_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL epoch_word%0d: got none expected %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL epoch_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    e = (got_q.size() > 1) ? got_q[1] : {1'b0, 32'hFFFFFFFF};
    checks++; if (e[31:8] !== 24'd0) begin errors++; $display("FAIL epoch_pad_bits: got %h expected 0", e[31:8]); end
`ifdef FACQ_PRN_PACKER_EPOCH_CNT_EN
    exp_ec = 16'd2;
`else
    exp_ec = 16'd0;
`endif
    checks++; if (epoch_cnt !== exp_ec) begin errors++; $display("FAIL epoch_cnt: got %0d expected %0d", epoch_cnt, exp_ec); end
    for (int i = 0; i < 80; i++) ep_samp[i] = samp[i];
  endtask

  task automatic test_valid_gaps();
    do_reset(16'd0);
    word_ready = 1'b1;
    for (int c = 0; c < 192; c++) begin
      if (c % 2 == 0) begin
        samp[sidx] = 1'($urandom_range(0, 1));
        run_cycle(1'b1, samp[sidx], 1'b0);
        sidx++;
      end else begin
        run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    drain(6);
    model_pack(96, 0);
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL gaps_word_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL gaps_word%0d: got none expected %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] head_ref;
    logic [W-1:0] w0;
    int stable_bad;
    do_reset(16'd0);
    word_ready = 1'b0;
    stable_bad = 0;
    head_ref = '0;
    for (int i = 0; i < 160; i++) begin
      samp[sidx] = 1'($urandom_range(0, 1));
      run_cycle(1'b1, samp[sidx], 1'b0);
      sidx++;
      if (i == 31) head_ref = word_data;
      if (i > 31 && !(word_valid === 1'b1 && word_data === head_ref && word_last === 1'b0)) stable_bad++;
      if (i == 127) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
      if (i == 159) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      end
    end
    for (int b = 0; b < W; b++) w0[b] = samp[b];
    checks++; if (head_ref !== w0) begin errors++; $display("FAIL ovf_head: got %h expected %h", head_ref, w0); end
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL ovf_head_stable: got %0d unstable cycles expected 0", stable_bad); end
    word_ready = 1'b1;
    feed(32);
    drain(8);
    model_pack(192, 0);
    exp_q.delete(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_word_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL ovf_word%0d: got none expected %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset(16'd0);
    word_ready = 1'b0;
    feed(159);
    word_ready = 1'b1;
    feed(1);
    word_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL fullpop_valid: got %b expected 1", word_valid); end
    word_ready = 1'b1;
    drain(8);
    model_pack(160, 0);
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL fullpop_word_count: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL fullpop_word%0d: got none expected %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sync();
    logic [15:0] exp_ec;
    do_reset(16'd40);
    word_ready = 1'b0;
    feed(160);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sync_pre_overflow: got %b expected 1", overflow); end
    feed(17);
    run_cycle(1'b1, 1'b1, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL sync_valid: got %b expected 0", word_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sync_overflow: got %b expected 0", overflow); end
    checks++; if (epoch_cnt !== 16'd0) begin errors++; $display("FAIL sync_epoch_cnt: got %0d expected 0", epoch_cnt); end
    sidx = 0;
    got_q.delete();
    exp_q.delete();
    word_ready = 1'b1;
    feed(80);
    drain(6);
    model_pack(80, 40);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL sync_word_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL sync_word%0d: got none expected %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sync_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
`ifdef FACQ_PRN_PACKER_EPOCH_CNT_EN
    exp_ec = 16'd2;
`else
    exp_ec = 16'd0;
`endif
    checks++; if (epoch_cnt !== exp_ec) begin errors++; $display("FAIL sync_epoch_cnt_after: got %0d expected %0d", epoch_cnt, exp_ec); end
  endtask

  task automatic test_rst_mid();
    do_reset(16'd40);
    word_ready = 1'b0;
    feed(50);
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", word_valid); end
    rst = 1'b1;
    word_ready = 1'b1;
    run_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", word_valid); end
    checks++; if (word_data !== 32'd0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", word_data); end
    checks++; if (word_last !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b expected 0", word_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b expected 0", overflow); end
    checks++; if (epoch_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_epoch_cnt: got %0d expected 0", epoch_cnt); end
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      samp[i] = ep_samp[i];
      run_cycle(1'b1, samp[i], 1'b0);
    end
    drain(6);
    model_pack(80, 40);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL rstmid_word_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL rstmid_word%0d: got none expected %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    sync_in    = 1'b0;
    epoch_len  = 16'd0;
    prn        = 1'b0;
    valid      = 1'b0;
    word_ready = 1'b0;
    sidx       = 0;
    test_reset();
    test_epoch();
    test_valid_gaps();
    test_overflow();
    test_full_pop();
    test_sync();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
